// File: rtl/ecg_beat_ctrl_if.sv
// ECG beat controller configuration handshake.
// Master offers step/rr with valid; slave accepts with ready.
interface ecg_beat_ctrl_if #(
   parameter int RR_W = 24
);
   logic            cfg_valid;
   logic            cfg_ready;
   logic [15:0]     cfg_step;
   logic [RR_W-1:0] cfg_rr;

   modport master (
      output cfg_valid,
      output cfg_step,
      output cfg_rr,
      input  cfg_ready
   );

   modport slave (
      input  cfg_valid,
      input  cfg_step,
      input  cfg_rr,
      output cfg_ready
   );
endinterface

// File: rtl/ecg_beat_ctrl.sv
// ECG beat playback controller: phase-accumulated ROM sweep per RR beat.
// Optional ECG_BEAT_SKIP_EN adds skip_req to rest through the next beat.
module ecg_beat_ctrl #(
   parameter int PHASE_W = 24,
   parameter int ADDR_W  = 8,
   parameter int RR_W    = 24
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run,
`ifdef ECG_BEAT_SKIP_EN
   input  logic              skip_req,
`endif
   ecg_beat_ctrl_if.slave    cfg,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              rom_en,
   output logic              beat_start,
   output logic              beat_overrun,
   output logic [1:0]        state
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SWEEP = 2'd1,
      REST  = 2'd2
   } st_e;

   st_e               state_q, state_d;
   logic [PHASE_W-1:0] phase_q, phase_d;
   logic [RR_W-1:0]   rr_cnt_q, rr_cnt_d;
   logic [15:0]       step_sh_q, step_sh_d;
   logic [15:0]       step_act_q, step_act_d;
   logic [RR_W-1:0]   rr_sh_q, rr_sh_d;
   logic [RR_W-1:0]   rr_act_q, rr_act_d;
   logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
   logic              rom_en_q, rom_en_d;
   logic              bs_q, bs_d;
   logic              ov_q, ov_d;
   logic              rdy_q, rdy_d;
   logic              skip_now;
   logic              new_beat;
   logic              rr_exp;
   logic [PHASE_W:0]  sum;

`ifdef ECG_BEAT_SKIP_EN
   logic skip_q, skip_d;
   assign skip_now = (state_q != IDLE) & (skip_q | skip_req);
`else
   assign skip_now = 1'b0;
`endif

   assign sum    = {1'b0, phase_q} + (PHASE_W+1)'(step_act_q);
   assign rr_exp = (rr_cnt_q == rr_act_q - RR_W'(1));

   always_comb begin
      state_d    = state_q;
      phase_d    = phase_q;
      rr_cnt_d   = rr_cnt_q;
      step_sh_d  = step_sh_q;
      rr_sh_d    = rr_sh_q;
      step_act_d = step_act_q;
      rr_act_d   = rr_act_q;
      bs_d       = 1'b0;
      ov_d       = 1'b0;
      new_beat   = 1'b0;

      if (cfg.cfg_valid && rdy_q) begin
         step_sh_d = (cfg.cfg_step == 16'd0) ? 16'd1 : cfg.cfg_step;
         rr_sh_d   = (cfg.cfg_rr < RR_W'(2)) ? RR_W'(2) : cfg.cfg_rr;
      end

      unique case (state_q)
         IDLE: begin
            if (run) new_beat = 1'b1;
         end
         SWEEP, REST: begin
            if (!run) begin
               state_d  = IDLE;
               phase_d  = '0;
               rr_cnt_d = '0;
            end else if (rr_exp) begin
               new_beat = 1'b1;
               // a sweep that just completed is not an overrun
               ov_d     = (state_q == SWEEP) & ~sum[PHASE_W];
            end else begin
               rr_cnt_d = rr_cnt_q + RR_W'(1);
               if (state_q == SWEEP) begin
                  if (sum[PHASE_W]) begin
                     state_d = REST;
                     phase_d = '0;
                  end else begin
                     phase_d = sum[PHASE_W-1:0];
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase

      // shadow values loaded this cycle are already visible via _d
      if (new_beat) begin
         step_act_d = step_sh_d;
         rr_act_d   = rr_sh_d;
         phase_d    = '0;
         rr_cnt_d   = '0;
         if (skip_now) begin
            state_d = REST;
         end else begin
            state_d = SWEEP;
            bs_d    = 1'b1;
         end
      end

      rom_en_d   = (state_d == SWEEP);
      rdy_d      = (state_d != SWEEP);
      rom_addr_d = rom_en_d ? phase_d[PHASE_W-1 -: ADDR_W] : '0;
   end

`ifdef ECG_BEAT_SKIP_EN
   always_comb begin
      skip_d = skip_now & ~new_beat & (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) skip_q <= 1'b0;
      else       skip_q <= skip_d;
   end
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         phase_q    <= '0;
         rr_cnt_q   <= '0;
         step_sh_q  <= 16'h0100;
         step_act_q <= 16'h0100;
         rr_sh_q    <= RR_W'(1000);
         rr_act_q   <= RR_W'(1000);
         rom_addr_q <= '0;
         rom_en_q   <= 1'b0;
         bs_q       <= 1'b0;
         ov_q       <= 1'b0;
         rdy_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         phase_q    <= phase_d;
         rr_cnt_q   <= rr_cnt_d;
         step_sh_q  <= step_sh_d;
         step_act_q <= step_act_d;
         rr_sh_q    <= rr_sh_d;
         rr_act_q   <= rr_act_d;
         rom_addr_q <= rom_addr_d;
         rom_en_q   <= rom_en_d;
         bs_q       <= bs_d;
         ov_q       <= ov_d;
         rdy_q      <= rdy_d;
      end
   end

   assign cfg.cfg_ready = rdy_q;
   assign rom_addr      = rom_addr_q;
   assign rom_en        = rom_en_q;
   assign beat_start    = bs_q;
   assign beat_overrun  = ov_q;
   assign state         = state_q;

endmodule

// File: tb/tb_ecg_beat_ctrl.sv
// Directed self-checking bench for ecg_beat_ctrl.
// Define ECG_BEAT_SKIP_EN to also exercise beat skipping.
module tb_ecg_beat_ctrl;

   logic       clk;
   logic       reset;
   logic       run;
   logic [7:0] rom_addr;
   logic       rom_en;
   logic       beat_start;
   logic       beat_overrun;
   logic [1:0] state;
`ifdef ECG_BEAT_SKIP_EN
   logic       skip_req;
`endif

   int checks;
   int errors;

   ecg_beat_ctrl_if #(.RR_W(24)) cfg_if ();

   ecg_beat_ctrl #(
      .PHASE_W(24),
      .ADDR_W (8),
      .RR_W   (24)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .run         (run),
`ifdef ECG_BEAT_SKIP_EN
      .skip_req    (skip_req),
`endif
      .cfg         (cfg_if.slave),
      .rom_addr    (rom_addr),
      .rom_en      (rom_en),
      .beat_start  (beat_start),
      .beat_overrun(beat_overrun),
      .state       (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int c,
                      input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s c=%0d observed=%h expected=%h", tag, c, obs, exp);
      end
   endtask

   // full output vector; rom_en and cfg_ready follow from state
   task automatic exp_out(input string tag, input int c, input logic [1:0] st,
                          input logic [7:0] ad, input logic bs, input logic ov);
      logic [13:0] o, e;
      o = {state, rom_en, rom_addr, beat_start, beat_overrun, cfg_if.cfg_ready};
      e = {st, (st == 2'd1), ad, bs, ov, (st != 2'd1)};
      chk(tag, c, 32'(o), 32'(e));
   endtask

   task automatic cfg_load(input logic [15:0] st, input logic [23:0] rr);
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_step  = st;
      cfg_if.cfg_rr    = rr;
      tick();
      cfg_if.cfg_valid = 1'b0;
   endtask

   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      run    = 1'b0;
      cfg_if.cfg_valid = 1'b0;
      cfg_if.cfg_step  = 16'h0;
      cfg_if.cfg_rr    = 24'd0;
`ifdef ECG_BEAT_SKIP_EN
      skip_req = 1'b0;
`endif
      tick();
      tick();
      chk("rst_outs", 0,
          32'({state, rom_en, rom_addr, beat_start, beat_overrun, cfg_if.cfg_ready}),
          32'd0);
      reset = 1'b0;
      tick();
      exp_out("rst_release", 0, 2'd0, 8'd0, 1'b0, 1'b0);

      // 0x8000 / 1000: 512 sweep cycles then 488 rest
      cfg_load(16'h8000, 24'd1000);
      run = 1'b1;
      for (int c = 0; c < 2000; c++) begin
         int cc;
         tick();
         cc = c % 1000;
         if (cc < 512) exp_out("t1_sweep", c, 2'd1, 8'(cc / 2), cc == 0, 1'b0);
         else          exp_out("t1_rest", c, 2'd2, 8'd0, 1'b0, 1'b0);
      end

      // 0x1000 / 3000: sweep truncated, overrun with new beat
      run = 1'b0;
      tick();
      exp_out("t2_idle", 0, 2'd0, 8'd0, 1'b0, 1'b0);
      cfg_load(16'h1000, 24'd3000);
      run = 1'b1;
      for (int c = 0; c < 3002; c++) begin
         tick();
         if (c < 3000)       exp_out("t2_sweep", c, 2'd1, 8'(c / 16), c == 0, 1'b0);
         else if (c == 3000) exp_out("t2_overrun", c, 2'd1, 8'd0, 1'b1, 1'b1);
         else                exp_out("t2_after", c, 2'd1, 8'd0, 1'b0, 1'b0);
      end

      // cfg offered during sweep, accepted in rest, used next beat
      run = 1'b0;
      tick();
      cfg_load(16'h8000, 24'd1000);
      run = 1'b1;
      for (int c = 0; c <= 3000; c++) begin
         int d;
         tick();
         d = c - 1000;
         if (c < 512)        exp_out("t3_sweepA", c, 2'd1, 8'(c / 2), c == 0, 1'b0);
         else if (c < 1000)  exp_out("t3_restA", c, 2'd2, 8'd0, 1'b0, 1'b0);
         else if (d < 1024)  exp_out("t3_sweepB", c, 2'd1, 8'(d / 4), d == 0, 1'b0);
         else if (c < 3000)  exp_out("t3_restB", c, 2'd2, 8'd0, 1'b0, 1'b0);
         else                exp_out("t3_beatC", c, 2'd1, 8'd0, 1'b1, 1'b0);
         if (c == 0) begin
            cfg_if.cfg_valid = 1'b1;
            cfg_if.cfg_step  = 16'h4000;
            cfg_if.cfg_rr    = 24'd2000;
         end
         if (c == 513) cfg_if.cfg_valid = 1'b0;
      end

      // step 0 / rr 1 saturate to 1 / 2
      run = 1'b0;
      tick();
      cfg_load(16'h0000, 24'd1);
      run = 1'b1;
      for (int c = 0; c < 10; c++) begin
         tick();
         exp_out("t4_min", c, 2'd1, 8'd0, (c % 2) == 0, ((c % 2) == 0) && (c > 0));
      end

      // run dropped mid-sweep, then restarted fresh
      run = 1'b0;
      tick();
      cfg_load(16'h8000, 24'd1000);
      run = 1'b1;
      for (int c = 0; c < 100; c++) begin
         tick();
         exp_out("t5_pre", c, 2'd1, 8'(c / 2), c == 0, 1'b0);
      end
      run = 1'b0;
      tick();
      exp_out("t5_idle", 0, 2'd0, 8'd0, 1'b0, 1'b0);
      run = 1'b1;
      for (int c = 0; c < 1000; c++) begin
         tick();
         if (c < 512) exp_out("t5_sweep", c, 2'd1, 8'(c / 2), c == 0, 1'b0);
         else         exp_out("t5_rest", c, 2'd2, 8'd0, 1'b0, 1'b0);
      end

      // handshake in the cycle right before beat start
      cfg_if.cfg_valid = 1'b1;
      cfg_if.cfg_step  = 16'h4000;
      cfg_if.cfg_rr    = 24'd2000;
      tick();
      cfg_if.cfg_valid = 1'b0;
      exp_out("t6_start", 0, 2'd1, 8'd0, 1'b1, 1'b0);
      for (int d = 1; d < 9; d++) begin
         tick();
         exp_out("t6_newstep", d, 2'd1, 8'(d / 4), 1'b0, 1'b0);
      end

      // async reset mid-beat, then defaults 0x0100 / 1000
      @(posedge clk);
      #3;
      reset = 1'b1;
      run   = 1'b0;
      #1;
      chk("t7_async", 0,
          32'({state, rom_en, rom_addr, beat_start, beat_overrun, cfg_if.cfg_ready}),
          32'd0);
      tick();
      reset = 1'b0;
      tick();
      exp_out("t7_ready", 0, 2'd0, 8'd0, 1'b0, 1'b0);
      run = 1'b1;
      for (int c = 0; c <= 1000; c++) begin
         tick();
         if (c < 1000) exp_out("t7_dflt", c, 2'd1, 8'(c / 256), c == 0, 1'b0);
         else          exp_out("t7_ovr", c, 2'd1, 8'd0, 1'b1, 1'b1);
      end

`ifdef ECG_BEAT_SKIP_EN
      // skip pulse in beat 1 rests beat 2; beat 3 sweeps
      run = 1'b0;
      tick();
      cfg_load(16'h8000, 24'd1000);
      run = 1'b1;
      for (int c = 0; c < 2600; c++) begin
         int b, cc;
         tick();
         b  = c / 1000;
         cc = c % 1000;
         if (b == 1)        exp_out("t8_skip", c, 2'd2, 8'd0, 1'b0, 1'b0);
         else if (cc < 512) exp_out("t8_sweep", c, 2'd1, 8'(cc / 2), cc == 0, 1'b0);
         else               exp_out("t8_rest", c, 2'd2, 8'd0, 1'b0, 1'b0);
         skip_req = (c == 10);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
